// File: rtl/fac_pg1_pkg.sv
// Shared definitions for the PWM speed link: decoder FSM states and speed code width.
// The PWM generator on the other end of the link uses the same speed width.
package fac_pg1_pkg;

  localparam int SPEED_W = 4;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the PWM pin plus single-cycle rise/fall strobes
// derived from the synchronized level.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pwm_in};
      prev_reg <= sync_reg[1];
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~prev_reg;
  assign fall  = ~sync_reg[1] & prev_reg;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Measures PWM period and high time, converts the duty to a 4-bit speed code,
// and reports lock, sticky period error and stuck-line timeouts.
module pwm_speed_decoder
  import fac_pg1_pkg::*;
#(
  parameter int PERIOD = 1024,
  parameter int TOL    = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [SPEED_W-1:0] speed,
  output logic               valid,
  output logic               locked,
  output logic               err
);

  localparam int STEP  = PERIOD / 16;
  localparam int SHIFT = $clog2(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] CODE_MAX = CNT_W'(2 ** SPEED_W - 1);

  logic level, rise, fall;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   period_cnt_reg, period_cnt_next;
  logic [CNT_W-1:0]   high_cnt_reg, high_cnt_next;
  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic               valid_reg, valid_next;
  logic               locked_reg, locked_next;
  logic               err_reg, err_next;
  logic               to_done_reg, to_done_next;

  logic [CNT_W-1:0]   period_inc, high_inc, high_shift;
  logic [SPEED_W-1:0] duty_code;
  logic               timeout, in_tol;

  // Counters cover the cycles after the opening rise up to and including the
  // closing edge, so the incremented value is the true edge-to-edge distance.
  assign period_inc = (period_cnt_reg == CNT_MAX) ? period_cnt_reg : period_cnt_reg + CNT_W'(1);
  assign high_inc   = (high_cnt_reg == CNT_MAX) ? high_cnt_reg : high_cnt_reg + CNT_W'(1);
  assign timeout    = (period_inc >= TIMEOUT);
  assign in_tol     = (period_inc >= LO_LIM) && (period_inc <= HI_LIM);
  assign high_shift = high_cnt_reg >> SHIFT;
  assign duty_code  = (high_shift > CODE_MAX) ? {SPEED_W{1'b1}} : high_shift[SPEED_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WAIT_RISE;
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
      speed_reg      <= '0;
      valid_reg      <= 1'b0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      to_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      period_cnt_reg <= period_cnt_next;
      high_cnt_reg   <= high_cnt_next;
      speed_reg      <= speed_next;
      valid_reg      <= valid_next;
      locked_reg     <= locked_next;
      err_reg        <= err_next;
      to_done_reg    <= to_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    period_cnt_next = period_cnt_reg;
    high_cnt_next   = high_cnt_reg;
    speed_next      = speed_reg;
    valid_next      = 1'b0;
    locked_next     = locked_reg;
    err_next        = err_reg;
    to_done_next    = to_done_reg;

    case (state_reg)
      WAIT_RISE: begin
        if (rise) begin
          state_next      = HIGH;
          period_cnt_next = '0;
          high_cnt_next   = '0;
          to_done_next    = 1'b0;
        end else if (fall) begin
          period_cnt_next = '0;
          to_done_next    = 1'b0;
        end else if (timeout && !to_done_reg) begin
          // One report per quiet stretch; re-armed only by an edge.
          speed_next      = level ? {SPEED_W{1'b1}} : '0;
          valid_next      = 1'b1;
          locked_next     = 1'b0;
          period_cnt_next = '0;
          to_done_next    = 1'b1;
        end else begin
          period_cnt_next = period_inc;
        end
      end

      HIGH: begin
        if (fall) begin
          state_next      = LOW;
          period_cnt_next = period_inc;
          high_cnt_next   = high_inc;
        end else if (timeout) begin
          state_next      = WAIT_RISE;
          speed_next      = {SPEED_W{1'b1}};
          valid_next      = 1'b1;
          locked_next     = 1'b0;
          period_cnt_next = '0;
          high_cnt_next   = '0;
          to_done_next    = 1'b1;
        end else begin
          period_cnt_next = period_inc;
          high_cnt_next   = high_inc;
        end
      end

      LOW: begin
        if (rise) begin
          state_next      = HIGH;
          period_cnt_next = '0;
          high_cnt_next   = '0;
          if (in_tol) begin
            speed_next  = duty_code;
            valid_next  = 1'b1;
            locked_next = 1'b1;
          end else begin
            err_next    = 1'b1;
            locked_next = 1'b0;
          end
        end else if (timeout) begin
          state_next      = WAIT_RISE;
          speed_next      = '0;
          valid_next      = 1'b1;
          locked_next     = 1'b0;
          period_cnt_next = '0;
          high_cnt_next   = '0;
          to_done_next    = 1'b1;
        end else begin
          period_cnt_next = period_inc;
        end
      end

      default: begin
        state_next      = WAIT_RISE;
        period_cnt_next = '0;
        high_cnt_next   = '0;
      end
    endcase
  end

  assign speed  = speed_reg;
  assign valid  = valid_reg;
  assign locked = locked_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Bench for pwm_speed_decoder: table of PWM periods plus hand-written timeout,
// tolerance and reset sequences; valid pulses are checked against a queue.
module tb_pwm_speed_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [3:0] speed;
  logic       valid, locked, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] speed;
    logic       locked;
  } exp_t;

  typedef struct {
    int         period;
    int         high;
    bit         ok;
    logic [3:0] speed;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[20];

  pwm_speed_decoder #(.PERIOD(1024), .TOL(32), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .speed  (speed),
    .valid  (valid),
    .locked (locked),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic l);
    exp_t e;
    e.speed  = s;
    e.locked = l;
    sb_q.push_back(e);
  endtask

  task automatic drive_high(input int n);
    pwm_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_low(input int n);
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid=1 speed=%0d expected no pulse (t=%0t)", speed, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("valid_speed", int'(speed), int'(e.speed));
        check("valid_locked", int'(locked), int'(e.locked));
        $display("txn: valid speed=%0d locked=%0d (expected %0d/%0d) t=%0t",
                 speed, locked, e.speed, e.locked, $time);
      end
    end
  end

  initial begin
    vecs[0] = '{1024, 512,  1'b1, 4'd8};
    vecs[1] = '{1024, 1023, 1'b1, 4'd15};
    vecs[2] = '{1024, 63,   1'b1, 4'd0};
    vecs[3] = '{1050, 512,  1'b1, 4'd8};
    for (int c = 0; c < 16; c++)
      vecs[4 + c] = '{1024, (c == 0) ? 16 : c * 64, 1'b1, 4'(c)};

    // Reset state
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_speed", int'(speed), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table: each period is evaluated at the rise that starts the next one
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && vecs[i-1].ok) push(vecs[i-1].speed, 1'b1);
      drive_high(vecs[i].high);
      drive_low(vecs[i].period - vecs[i].high);
    end
    push(vecs[19].speed, 1'b1);

    // Out-of-tolerance period: err set, lock dropped, speed held, no pulse
    drive_high(512);
    drive_low(1100 - 512);
    drive_high(20);
    check("tol_err", int'(err), 1);
    check("tol_locked", int'(locked), 0);
    check("tol_speed_held", int'(speed), int'(vecs[19].speed));
    check("tol_no_valid_pending", sb_q.size(), 0);
    drive_high(492);
    drive_low(512);

    // Stuck high after a good period
    push(4'd8, 1'b1);
    push(4'd15, 1'b0);
    drive_high(2048 + 50);
    check("stuck_high_speed", int'(speed), 15);
    check("stuck_high_locked", int'(locked), 0);
    check("stuck_high_drained", sb_q.size(), 0);

    // Relock, then stuck low from LOW
    drive_low(512);
    drive_high(512);
    drive_low(512);
    push(4'd8, 1'b1);
    drive_high(512);
    push(4'd0, 1'b0);
    drive_low(2048 + 2 * 2048 + 100);
    check("stuck_low_speed", int'(speed), 0);
    check("stuck_low_locked", int'(locked), 0);
    check("stuck_low_drained", sb_q.size(), 0);
    check("err_sticky", int'(err), 1);

    // Reset in the middle of a HIGH phase
    drive_high(512);
    drive_low(512);
    push(4'd8, 1'b1);
    drive_high(100);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_speed", int'(speed), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_drained", sb_q.size(), 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // First valid only after the second full rise
    drive_high(512);
    drive_low(512);
    check("post_rst_locked_before", int'(locked), 0);
    push(4'd8, 1'b1);
    drive_high(512);
    drive_low(512);
    repeat (100) @(negedge clk);
    check("post_rst_drained", sb_q.size(), 0);
    check("post_rst_speed", int'(speed), 8);
    check("post_rst_locked", int'(locked), 1);
    check("post_rst_err", int'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
